// File: rtl/demux_1x8_reg_if.sv
// Producer/consumer bundle for the registered 1-to-8 demultiplexer.
// The master side drives the input stream and consumer readies; the slave side is the demux.
interface demux_1x8_reg_if #(
   parameter int unsigned WIDTH = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [2:0]         sel;
   logic [7:0]         out_valid;
   logic [7:0]         out_ready;
   logic [8*WIDTH-1:0] out_data;

   modport master (
      output in_valid,
      input  in_ready,
      output in_data,
      output sel,
      input  out_valid,
      output out_ready,
      input  out_data
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_data,
      input  sel,
      output out_valid,
      input  out_ready,
      output out_data
   );
endinterface

// File: rtl/demux_1x8_reg.sv
// Registered 1-to-8 demux: one tagged input stream into eight single-entry drain buffers.
// Optional DEMUX_ZERO_IDLE_EN forces each idle output slice to zero.
module demux_1x8_reg #(
   parameter int unsigned WIDTH = 32
) (
   input logic              clk,
   input logic              rst,
   demux_1x8_reg_if.slave   bus
);

   logic [7:0]       ch_v;
   logic [WIDTH-1:0] ch_d [8];
   logic             accept;

   // Only sel/out_ready reach in_ready combinationally; in_valid/in_data only feed registers.
   assign bus.in_ready = ~ch_v[bus.sel] | bus.out_ready[bus.sel];
   assign accept       = bus.in_valid & bus.in_ready;

   // An accept into a draining channel keeps it full and loads the new word.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_v <= '0;
         for (int k = 0; k < 8; k++) begin
            ch_d[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (accept && (bus.sel == 3'(k))) begin
               ch_v[k] <= 1'b1;
               ch_d[k] <= bus.in_data;
            end else if (bus.out_ready[k]) begin
               ch_v[k] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      bus.out_valid = ch_v;
      bus.out_data  = '0;
      for (int k = 0; k < 8; k++) begin
`ifdef DEMUX_ZERO_IDLE_EN
         bus.out_data[k*WIDTH +: WIDTH] = ch_v[k] ? ch_d[k] : '0;
`else
         bus.out_data[k*WIDTH +: WIDTH] = ch_d[k];
`endif
      end
   end

endmodule
